// File: rtl/wb_regfile_scoreboard_pkg.sv
// Shared definitions for the writeback register file / pending-write scoreboard.
//   DATA_W, ADDR_W : default register width and register-name width
//   NREGS          : number of architectural registers (2**ADDR_W)
//   REG_ZERO       : name of the hardwired-zero register
//   reg_name_t     : register-name type
//   data_t         : data-word type
//   reg_onehot()   : one-hot decode of a register name, R0 never selected
package wb_regfile_scoreboard_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned NREGS  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_name_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam reg_name_t REG_ZERO = {ADDR_W{1'b0}};

    // One-hot select for a register name; R0 is never selected because it
    // can neither be written nor reserved.
    function automatic logic [NREGS-1:0] reg_onehot(input reg_name_t name);
        logic [NREGS-1:0] hot;
        hot       = {NREGS{1'b0}};
        hot[name] = 1'b1;
        hot[0]    = 1'b0;
        return hot;
    endfunction

endpackage

// File: rtl/wb_regfile_scoreboard_if.sv
// Bus bundle between the pipeline and the writeback register file.
//   wr_en/wr_reg/wr_data   : writeback port from the writeback select mux
//   rsv_en/rsv_reg         : decode-stage destination reservation
//   flush                  : drop all reservations
//   rd_reg1/rd_reg2        : decode read-port register names
//   rd_data1/rd_data2      : read data
//   rd_pend1/rd_pend2      : read-port register has an outstanding write
//   any_pend               : some register has an outstanding write
// Modports: master (pipeline side), slave (register file side).
interface wb_regfile_scoreboard_if;
    import wb_regfile_scoreboard_pkg::*;

    logic      wr_en;
    reg_name_t wr_reg;
    data_t     wr_data;
    logic      rsv_en;
    reg_name_t rsv_reg;
    logic      flush;
    reg_name_t rd_reg1;
    reg_name_t rd_reg2;
    data_t     rd_data1;
    data_t     rd_data2;
    logic      rd_pend1;
    logic      rd_pend2;
    logic      any_pend;

    modport master (
        output wr_en, wr_reg, wr_data, rsv_en, rsv_reg, flush, rd_reg1, rd_reg2,
        input  rd_data1, rd_data2, rd_pend1, rd_pend2, any_pend
    );

    modport slave (
        input  wr_en, wr_reg, wr_data, rsv_en, rsv_reg, flush, rd_reg1, rd_reg2,
        output rd_data1, rd_data2, rd_pend1, rd_pend2, any_pend
    );

endinterface

// File: rtl/wb_regfile_scoreboard_readport.sv
// One decode read port of the register file.
//   regs    : current register contents
//   pend    : registered pending-write bits
//   rd_reg  : register name to read
//   wr_hot, rsv_hot, wr_data : same-cycle writeback/reservation (only when
//             WB_BYPASS_EN is defined; enables write-before-read forwarding)
//   rd_data : read data (combinational), R0 reads as zero
//   rd_pend : pending-write status of rd_reg
// Optional feature macro: WB_BYPASS_EN.
module wb_regfile_readport
    import wb_regfile_scoreboard_pkg::*;
(
    input  data_t            regs [NREGS],
    input  logic [NREGS-1:0] pend,
    input  reg_name_t        rd_reg,
`ifdef WB_BYPASS_EN
    input  logic [NREGS-1:0] wr_hot,
    input  logic [NREGS-1:0] rsv_hot,
    input  data_t            wr_data,
`endif
    output data_t            rd_data,
    output logic             rd_pend
);

    // Register select with R0 zeroing and optional same-cycle forwarding.
    always_comb begin
        rd_data = {DATA_W{1'b0}};
        rd_pend = 1'b0;
        if (rd_reg == REG_ZERO) begin
            rd_data = {DATA_W{1'b0}};
            rd_pend = 1'b0;
        end
`ifdef WB_BYPASS_EN
        else if (wr_hot[rd_reg]) begin
            // Forwarded data is final unless a new producer reserves the
            // register in this same cycle; then the registered bit stands.
            rd_data = wr_data;
            rd_pend = pend[rd_reg] & rsv_hot[rd_reg];
        end
`endif
        else begin
            rd_data = regs[rd_reg];
            rd_pend = pend[rd_reg];
        end
    end

endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Architectural register file plus pending-write scoreboard at the end of the
// writeback path.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears registers and pending bits)
//   bus   : wb_regfile_scoreboard_if.slave (write, reserve, flush, two reads)
// Optional feature macro: WB_BYPASS_EN (same-cycle writeback forwarding to
// the read ports). Without it, reads see the old value until the next edge.
module wb_regfile_scoreboard
    import wb_regfile_scoreboard_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    wb_regfile_scoreboard_if.slave  bus
);

    data_t            regs_q [NREGS];
    data_t            regs_d [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [NREGS-1:0] wr_hot_s;
    logic [NREGS-1:0] rsv_hot_s;

    // Decode the write and reserve names into per-register strobes.
    always_comb begin
        wr_hot_s  = {NREGS{1'b0}};
        rsv_hot_s = {NREGS{1'b0}};
        if (bus.wr_en) begin
            wr_hot_s = reg_onehot(bus.wr_reg);
        end else begin
            wr_hot_s = {NREGS{1'b0}};
        end
        if (bus.rsv_en) begin
            rsv_hot_s = reg_onehot(bus.rsv_reg);
        end else begin
            rsv_hot_s = {NREGS{1'b0}};
        end
    end

    // Next register contents: the writeback lands regardless of flush.
    always_comb begin
        regs_d = regs_q;
        for (int r = 1; r < NREGS; r++) begin
            if (wr_hot_s[r]) begin
                regs_d[r] = bus.wr_data;
            end else begin
                regs_d[r] = regs_q[r];
            end
        end
        regs_d[0] = {DATA_W{1'b0}};
    end

    // Next pending bits: flush, then reserve (new producer beats the
    // retiring one), then writeback clear, else hold.
    always_comb begin
        pend_d = pend_q;
        for (int r = 1; r < NREGS; r++) begin
            if (bus.flush) begin
                pend_d[r] = 1'b0;
            end else if (rsv_hot_s[r]) begin
                pend_d[r] = 1'b1;
            end else if (wr_hot_s[r]) begin
                pend_d[r] = 1'b0;
            end else begin
                pend_d[r] = pend_q[r];
            end
        end
        pend_d[0] = 1'b0;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: {DATA_W{1'b0}}};
            pend_q <= {NREGS{1'b0}};
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    // Summary flag uses registered bits only; forwarding does not affect it.
    always_comb begin
        bus.any_pend = |pend_q;
    end

    wb_regfile_readport u_rd1 (
        .regs    (regs_q),
        .pend    (pend_q),
        .rd_reg  (bus.rd_reg1),
`ifdef WB_BYPASS_EN
        .wr_hot  (wr_hot_s),
        .rsv_hot (rsv_hot_s),
        .wr_data (bus.wr_data),
`endif
        .rd_data (bus.rd_data1),
        .rd_pend (bus.rd_pend1)
    );

    wb_regfile_readport u_rd2 (
        .regs    (regs_q),
        .pend    (pend_q),
        .rd_reg  (bus.rd_reg2),
`ifdef WB_BYPASS_EN
        .wr_hot  (wr_hot_s),
        .rsv_hot (rsv_hot_s),
        .wr_data (bus.wr_data),
`endif
        .rd_data (bus.rd_data2),
        .rd_pend (bus.rd_pend2)
    );

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed self-checking bench for wb_regfile_scoreboard. Expected read-port
// values are queued when a step is driven and compared after settling.
module tb_wb_regfile_scoreboard;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    wb_regfile_scoreboard_if bus ();

    wb_regfile_scoreboard dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] d1;
        logic        p1;
        logic [15:0] d2;
        logic        p2;
        logic        ap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [15:0] d1, input logic p1,
                        input logic [15:0] d2, input logic p2, input logic ap);
        exp_t e;
        e.tag = tag; e.d1 = d1; e.p1 = p1; e.d2 = d2; e.p2 = p2; e.ap = ap;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.tag, "/rd_data1"}, bus.rd_data1, e.d1);
            cmp({e.tag, "/rd_pend1"}, {15'd0, bus.rd_pend1}, {15'd0, e.p1});
            cmp({e.tag, "/rd_data2"}, bus.rd_data2, e.d2);
            cmp({e.tag, "/rd_pend2"}, {15'd0, bus.rd_pend2}, {15'd0, e.p2});
            cmp({e.tag, "/any_pend"}, {15'd0, bus.any_pend}, {15'd0, e.ap});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        bus.wr_en  = 1'b0;
        bus.rsv_en = 1'b0;
        bus.flush  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] r, input logic [15:0] d);
        bus.wr_en = 1'b1; bus.wr_reg = r; bus.wr_data = d;
    endtask

    task automatic rsv(input logic [3:0] r);
        bus.rsv_en = 1'b1; bus.rsv_reg = r;
    endtask

    task automatic rd(input logic [3:0] r1, input logic [3:0] r2);
        bus.rd_reg1 = r1; bus.rd_reg2 = r2;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_reg  = 4'd0;
        bus.wr_data = 16'h0000;
        bus.rsv_en  = 1'b0;
        bus.rsv_reg = 4'd0;
        bus.flush   = 1'b0;
        bus.rd_reg1 = 4'd0;
        bus.rd_reg2 = 4'd0;

        // 1: reset state of every register
        @(negedge clk);
        for (int r = 0; r < 16; r++) begin
            rd(4'(r), 4'(15 - r));
            push($sformatf("t1_reset_r%0d", r), 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
            check_now();
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // 2: plain write, then R0 write ignored
        wr(4'd5, 16'hBEEF);
        tick();
        rd(4'd5, 4'd5);
        push("t2_r5", 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 1'b0);
        check_now();
        wr(4'd0, 16'h1234);
        rd(4'd0, 4'd5);
        push("t2_r0_same", 16'h0000, 1'b0, 16'hBEEF, 1'b0, 1'b0);
        check_now();
        tick();
        push("t2_r0", 16'h0000, 1'b0, 16'hBEEF, 1'b0, 1'b0);
        check_now();

        // 3: reserve, then retiring writeback clears
        rsv(4'd3);
        tick();
        rd(4'd5, 4'd3);
        push("t3_pend", 16'hBEEF, 1'b0, 16'h0000, 1'b1, 1'b1);
        check_now();
        wr(4'd3, 16'h00A5);
        push("t3_wb_same", 16'hBEEF, 1'b0, BYP ? 16'h00A5 : 16'h0000, ~BYP, 1'b1);
        check_now();
        tick();
        push("t3_done", 16'hBEEF, 1'b0, 16'h00A5, 1'b0, 1'b0);
        check_now();

        // 4: same-cycle reserve and writeback of a pending register
        rsv(4'd7);
        tick();
        rd(4'd7, 4'd3);
        rsv(4'd7);
        wr(4'd7, 16'h0042);
        push("t4_same", BYP ? 16'h0042 : 16'h0000, 1'b1, 16'h00A5, 1'b0, 1'b1);
        check_now();
        tick();
        push("t4_after", 16'h0042, 1'b1, 16'h00A5, 1'b0, 1'b1);
        check_now();
        wr(4'd7, 16'h0043);
        push("t4_clr_same", BYP ? 16'h0043 : 16'h0042, ~BYP, 16'h00A5, 1'b0, 1'b1);
        check_now();
        tick();
        push("t4_clr", 16'h0043, 1'b0, 16'h00A5, 1'b0, 1'b0);
        check_now();

        // 5: forwarding on both ports naming the same register
        rsv(4'd9);
        tick();
        rd(4'd9, 4'd9);
        wr(4'd9, 16'h5A5A);
        push("t5_byp", BYP ? 16'h5A5A : 16'h0000, ~BYP,
                       BYP ? 16'h5A5A : 16'h0000, ~BYP, 1'b1);
        check_now();
        tick();
        push("t5_after", 16'h5A5A, 1'b0, 16'h5A5A, 1'b0, 1'b0);
        check_now();
        // untracked write leaves pend clear
        wr(4'd10, 16'h1111);
        tick();
        rd(4'd10, 4'd9);
        push("t5_untracked", 16'h1111, 1'b0, 16'h5A5A, 1'b0, 1'b0);
        check_now();
        // double reservation is a single bit
        rsv(4'd11);
        tick();
        rsv(4'd11);
        tick();
        rd(4'd11, 4'd9);
        push("t5_dbl_rsv", 16'h0000, 1'b1, 16'h5A5A, 1'b0, 1'b1);
        check_now();
        wr(4'd11, 16'h2222);
        tick();
        push("t5_dbl_clr", 16'h2222, 1'b0, 16'h5A5A, 1'b0, 1'b0);
        check_now();

        // 6: flush overrides reserve, write still lands
        rsv(4'd1);
        tick();
        rsv(4'd2);
        tick();
        rsv(4'd4);
        tick();
        rd(4'd1, 4'd4);
        push("t6_rsv", 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1);
        check_now();
        bus.flush = 1'b1;
        wr(4'd2, 16'h7777);
        rsv(4'd6);
        rd(4'd2, 4'd6);
        push("t6_flush_same", BYP ? 16'h7777 : 16'h0000, ~BYP, 16'h0000, 1'b0, 1'b1);
        check_now();
        tick();
        push("t6_flush", 16'h7777, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_now();
        rd(4'd1, 4'd4);
        push("t6_flush_r1r4", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_now();

        // 6: asynchronous reset during a write drops it and clears state
        rsv(4'd13);
        tick();
        wr(4'd12, 16'hABCD);
        rd(4'd12, 4'd5);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.wr_en = 1'b0;
        rst_n = 1'b1;
        push("t6_rst", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_now();
        wr(4'd12, 16'hABCD);
        tick();
        push("t6_post_rst", 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_now();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
